// File: rtl/load_queue.sv
`timescale 1ns/1ps
// load_queue: in-order FIFO of RV32 loads from the reservation station.
// Issues one memory-controller read at a time and writes the extended
// result back to the instruction queue. A flush discards everything queued;
// a read still outstanding at the flush is absorbed in DRAIN.
module load_queue #(
  parameter  int DEPTH     = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int IQ_ADDR_W = 5,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear_flag_in,
  input  logic                 rs_load_enable_in,
  input  logic [2:0]           rs_func3_in,
  input  logic [ADDR_W-1:0]    rs_addr_in,
  input  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in,
  output logic                 rs_full_out,
  output logic [CNT_W-1:0]     count_out,
  output logic                 mc_fetch_enable_out,
  output logic [ADDR_W-1:0]    mc_addr_out,
  output logic [1:0]           mc_len_out,
  input  logic                 mc_result_enable_in,
  input  logic [DATA_W-1:0]    mc_data_in,
  output logic                 iq_write_enable_out,
  output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
  output logic [DATA_W-1:0]    iq_write_result_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [2:0]           func3;
    logic [IQ_ADDR_W-1:0] pos;
  } entry_t;

  entry_t                entry_q [DEPTH];
  entry_t                head_entry;
  state_t                state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fetch_q, fetch_d;
  logic [ADDR_W-1:0]     mc_addr_q, mc_addr_d;
  logic [1:0]            mc_len_q, mc_len_d;
  logic                  wb_q, wb_d;
  logic [IQ_ADDR_W-1:0]  iq_idx_q, iq_idx_d;
  logic [DATA_W-1:0]     iq_res_q, iq_res_d;
  logic                  push;
  logic                  pop;

  // Byte/half results are sign-extended unless funct3[2] selects the unsigned form.
  function automatic logic [DATA_W-1:0] extend_load(input logic [2:0] func3,
                                                     input logic [DATA_W-1:0] data);
    logic fill;
    fill = 1'b0;
    case (func3[1:0])
      2'd0: begin
        fill        = ~func3[2] & data[7];
        extend_load = {{(DATA_W-8){fill}}, data[7:0]};
      end
      2'd1: begin
        fill        = ~func3[2] & data[15];
        extend_load = {{(DATA_W-16){fill}}, data[15:0]};
      end
      default: extend_load = data;
    endcase
  endfunction

  // Controller length code: word is encoded as 3, byte/half pass straight through.
  function automatic logic [1:0] mem_len(input logic [2:0] func3);
    mem_len = (func3[1:0] == 2'd2) ? 2'd3 : func3[1:0];
  endfunction

  assign head_entry          = entry_q[head_q];
  assign rs_full_out         = (count_q == CNT_W'(DEPTH));
  assign count_out           = count_q;
  assign mc_addr_out         = mc_addr_q;
  assign mc_len_out          = mc_len_q;
  assign iq_write_idx_out    = iq_idx_q;
  assign iq_write_result_out = iq_res_q;
  // Pulses stay registered while frozen, so mask them to read 0 when rdy is low.
  assign mc_fetch_enable_out = fetch_q & rdy;
  assign iq_write_enable_out = wb_q & rdy;

  // Next-state, issue/writeback and FIFO pointer logic; flush overrides the pointers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    fetch_d  = 1'b0;
    mc_addr_d = mc_addr_q;
    mc_len_d = mc_len_q;
    wb_d     = 1'b0;
    iq_idx_d = iq_idx_q;
    iq_res_d = iq_res_q;
    pop      = 1'b0;
    push     = rs_load_enable_in && !rs_full_out && !clear_flag_in;

    case (state_q)
      IDLE: begin
        if (!clear_flag_in && count_q != '0) begin
          fetch_d   = 1'b1;
          mc_addr_d = head_entry.addr;
          mc_len_d  = mem_len(head_entry.func3);
          state_d   = LOADING;
        end
      end
      LOADING: begin
        if (mc_result_enable_in) begin
          state_d = IDLE;
          if (!clear_flag_in) begin
            wb_d     = 1'b1;
            iq_idx_d = head_entry.pos;
            iq_res_d = extend_load(head_entry.func3, mc_data_in);
            pop      = 1'b1;
          end
        end else if (clear_flag_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mc_result_enable_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear_flag_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control and output registers: reset wins, rdy low freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      fetch_q   <= 1'b0;
      mc_addr_q <= '0;
      mc_len_q  <= '0;
      wb_q      <= 1'b0;
      iq_idx_q  <= '0;
      iq_res_q  <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      fetch_q   <= fetch_d;
      mc_addr_q <= mc_addr_d;
      mc_len_q  <= mc_len_d;
      wb_q      <= wb_d;
      iq_idx_q  <= iq_idx_d;
      iq_res_q  <= iq_res_d;
    end
  end

  // Queue storage written at the tail on an accepted enqueue.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is not reset; count/head/tail alone say which entries are valid.
    if (!rst && rdy && push) begin
      entry_q[tail_q] <= '{addr: rs_addr_in, func3: rs_func3_in, pos: rs_pos_in_iq_in};
    end
  end

endmodule
